// File: rtl/pc_ctrl.sv
// Fetch program counter with ID redirects and a redirect captured while stalled.
// Optional PC_RANGE_CHECK_EN adds a sticky fault flag for a pc outside instruction memory.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pend_valid,
    output logic [31:0] fetch_cnt,
    output logic        pc_fault
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_pc;
    logic [31:0] target;

    // Word-aligned redirect target; low address bits from ID are ignored.
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign pc4        = pc + 32'd4;
    assign pend_valid = (state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            pend_pc   <= 32'd0;
            fetch_cnt <= 32'd0;
        end else if (!stall) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= RUN;
            pend_pc   <= 32'd0;
            // A live redirect outranks one captured during the stall.
            if (redirect_valid) begin
                pc <= target;
            end else if (state == HOLD) begin
                pc <= pend_pc;
            end else begin
                pc <= pc4;
            end
        end else if (redirect_valid) begin
            pend_pc <= target;
            state   <= HOLD;
        end
    end

`ifdef PC_RANGE_CHECK_EN
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    logic pc_out_of_range;

    assign pc_out_of_range = (pc < RESET_PC) || ({1'b0, pc} >= PC_LIMIT);

    // Sticky until reset; looks at the pc already registered, so it lags one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_fault <= 1'b0;
        end else if (pc_out_of_range) begin
            pc_fault <= 1'b1;
        end
    end
`else
    logic unused_im_words;

    assign unused_im_words = (IM_WORDS > 0);
    assign pc_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: sequential fetch, redirects, stall capture, async reset,
// wrap-around and the range-check flag (expected 0 unless PC_RANGE_CHECK_EN is defined).
module tb_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pend_valid;
    logic [31:0] fetch_cnt;
    logic        pc_fault;

    int total;
    int bad;
    logic fault_exp;

    pc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc4            (pc4),
        .pend_valid     (pend_valid),
        .fetch_cnt      (fetch_cnt),
        .pc_fault       (pc_fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] rp);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef PC_RANGE_CHECK_EN
        fault_exp = 1'b1;
`else
        fault_exp = 1'b0;
`endif
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        #12;
        check("rst_pc", pc, 32'h3000);
        check("rst_pc4", pc4, 32'h3004);
        check("rst_pend", 32'(pend_valid), 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_fault", 32'(pc_fault), 32'd0);
        reset = 1'b0;

        // free running
        step(); check("seq1", pc, 32'h3004);
        step(); check("seq2", pc, 32'h3008);
        step(); check("seq3", pc, 32'h300C);
        step(); check("seq4", pc, 32'h3010);
        check("seq_cnt", fetch_cnt, 32'd4);

        // redirect with misaligned target, one-edge latency
        drive(1'b0, 1'b1, 32'h3043);
        check("redir_pre", pc, 32'h3010);
        step(); check("redir_pc", pc, 32'h3040);
        drive(1'b0, 1'b0, 32'h0);
        step(); check("redir_next", pc, 32'h3044);
        check("redir_pc4", pc4, 32'h3048);
        check("redir_cnt", fetch_cnt, 32'd6);

        // plain stall at 0x3008
        pulse_reset();
        step(); step();
        check("st_pre", pc, 32'h3008);
        drive(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold_pc", pc, 32'h3008);
            check("st_hold_cnt", fetch_cnt, 32'd2);
            check("st_hold_pend", 32'(pend_valid), 32'd0);
        end
        drive(1'b0, 1'b0, 32'h0);
        step(); check("st_rel", pc, 32'h300C);
        check("st_rel_cnt", fetch_cnt, 32'd3);

        // two redirects while stalled, newest wins
        drive(1'b1, 1'b1, 32'h3100);
        step(); check("cap1_pc", pc, 32'h300C);
        check("cap1_pend", 32'(pend_valid), 32'd1);
        drive(1'b1, 1'b1, 32'h3200);
        step(); check("cap2_pend", 32'(pend_valid), 32'd1);
        drive(1'b1, 1'b0, 32'h0);
        step(); check("cap3_pend", 32'(pend_valid), 32'd1);
        check("cap3_pc", pc, 32'h300C);
        check("cap3_cnt", fetch_cnt, 32'd3);
        drive(1'b0, 1'b0, 32'h0);
        step(); check("cap_rel_pc", pc, 32'h3200);
        check("cap_rel_pend", 32'(pend_valid), 32'd0);
        check("cap_rel_cnt", fetch_cnt, 32'd4);
        step(); check("cap_after", pc, 32'h3204);

        // live redirect outranks pending
        drive(1'b1, 1'b1, 32'h3100);
        step(); check("live_pend", 32'(pend_valid), 32'd1);
        drive(1'b0, 1'b1, 32'h3300);
        step(); check("live_pc", pc, 32'h3300);
        check("live_pend0", 32'(pend_valid), 32'd0);
        check("live_cnt", fetch_cnt, 32'd6);
        drive(1'b0, 1'b0, 32'h0);
        step(); check("live_after", pc, 32'h3304);

        // asynchronous reset mid-stall with a pending redirect
        drive(1'b1, 1'b1, 32'h3100);
        step(); check("ar_pend", 32'(pend_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_pc", pc, 32'h3000);
        check("ar_pend0", 32'(pend_valid), 32'd0);
        check("ar_cnt", fetch_cnt, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        step(); check("ar_resume", pc, 32'h3004);
        check("ar_resume_cnt", fetch_cnt, 32'd1);

        // wrap-around at top of address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(); check("wrap_top", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0000_0000);
        drive(1'b0, 1'b0, 32'h0);
        step(); check("wrap_pc", pc, 32'h0000_0000);

        // range check flag
        pulse_reset();
        check("rng_rst", 32'(pc_fault), 32'd0);
        drive(1'b0, 1'b1, 32'h3FFC);
        step(); check("rng_last_ok", pc, 32'h3FFC);
        drive(1'b0, 1'b1, 32'h4000);
        step(); check("rng_pc", pc, 32'h4000);
        check("rng_not_yet", 32'(pc_fault), 32'd0);
        drive(1'b0, 1'b1, 32'h3000);
        step(); check("rng_back", pc, 32'h3000);
        check("rng_set", 32'(pc_fault), 32'(fault_exp));
        drive(1'b0, 1'b0, 32'h0);
        step(); check("rng_sticky", 32'(pc_fault), 32'(fault_exp));
        pulse_reset();
        check("rng_clear", 32'(pc_fault), 32'd0);
        step(); check("rng_clear2", 32'(pc_fault), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Program-counter stage directly upstream of the instruction fetch unit. Holds the architectural fetch PC and drives it into the fetch unit each cycle.
- Computes the next PC from three sources: sequential PC+4, a redirect from ID (branch/jump/jr, delay-slot semantics), or a redirect captured while the pipeline was stalled.
- Provides a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 1024, instruction memory depth in words; used only by the range check.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold request; PC must not advance.
- redirect_valid  in  1  ID stage requests a non-sequential next PC.
- redirect_pc  in  32  target PC from ID (beq/bne/j/jal/jr).
- pc  out  32  current fetch PC to the fetch unit.
- pc4  out  32  pc + 4, combinational.
- pend_valid  out  1  a captured redirect is waiting.
- fetch_cnt  out  32  count of cycles in which pc advanced.
- pc_fault  out  1  range-check flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or mid-stall):
  - pc = RESET_PC, pend_valid = 0, internal pend_pc = 0, fetch_cnt = 0, pc_fault = 0.
  - State = RUN.
- States:
  - RUN: no pending redirect.
  - HOLD: pending redirect held; pend_valid = 1 exactly in HOLD.
- Target selection:
  - redirect_pc[1:0] is ignored; the captured or applied target has bits [1:0] forced to 2'b00.
  - A live redirect always outranks a pending one.
- Cycle rules, evaluated each rising edge:
  - stall=0, redirect_valid=1: pc <= redirect_pc; pending cleared; state -> RUN.
  - stall=0, redirect_valid=0, state HOLD: pc <= pend_pc; state -> RUN.
  - stall=0, redirect_valid=0, state RUN: pc <= pc + 4.
  - stall=1, redirect_valid=1: pc held; pend_pc <= redirect_pc; state -> HOLD. A newer redirect overwrites an older pending one.
  - stall=1, redirect_valid=0: pc and pend state held.
- Latency and delay slot:
  - A redirect takes effect on the PC one edge after it is presented when not stalled.
  - The instruction fetched in the cycle the redirect is presented is the delay slot. This block never squashes it.
- Arithmetic:
  - pc4 = pc + 32'd4, modulo 2^32. pc = 32'hFFFF_FFFC advances to 32'h0000_0000, with no flag.
- fetch_cnt:
  - Increments by 1 on every edge with stall=0.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Holds on stall.
- No combinational path from any input to pc, pend_valid, fetch_cnt, or pc_fault. pc4 depends only on pc.

Optional Feature:
- Macro: PC_RANGE_CHECK_EN.
- Defined:
  - pc_fault is set on the first edge at which the new pc lies outside [RESET_PC, RESET_PC + 4*IM_WORDS).
  - The flag is sticky until reset.
  - It is registered, so it rises on the edge after the illegal pc appears.
  - PC behaviour is otherwise unchanged.
- Not defined: pc_fault is tied to 0 and no comparator logic is present. The port always exists.

Test Plan:
- Reset then 4 free-running edges -> pc = 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; fetch_cnt = 4.
- pc = 0x3010, redirect_valid=1, redirect_pc = 0x3043 for one cycle -> next pc = 0x3040, then 0x3044.
- stall=1 for 3 cycles with pc = 0x3008 -> pc holds at 0x3008, fetch_cnt unchanged; release -> 0x300C.
- stall=1; redirect 0x3100 in cycle 1, redirect 0x3200 in cycle 2; release with no redirect:
  - pend_valid = 1 during the stall.
  - pc -> 0x3200, then pend_valid = 0.
- Pending 0x3100 and release with simultaneous live redirect 0x3300 -> pc = 0x3300, pend_valid = 0. Then assert reset mid-stall with pending -> pc = 0x3000, pend_valid = 0, fetch_cnt = 0 immediately (asynchronous).
- With PC_RANGE_CHECK_EN: redirect to 0x4000 -> pc_fault = 1 one edge later, stays 1 after a return to 0x3000, clears only on reset. Without the macro: pc_fault = 0 throughout.
